hx711_io_target: RTL and testbench

- Responder on the external IO bus driven by the HPS-side bridge (address / bus_enable / byte_enable / rw / write_data / read_data / acknowledge / irq). It answers bus transactions with a small register file.
- Behind the register file sits an HX711 load-cell serial engine. The engine drives SCK, shifts in 24-bit two's-complement samples, and raises io_irq when a sample is ready.
- Replaces the PIO-polled bit-banging of the scale for the cart weight path.

---
 rtl/hx711_io_pkg.sv | 45 ++++
 rtl/hx711_shifter.sv | 106 ++++++++++
 rtl/hx711_io_target.sv | 109 ++++++++++
 tb/tb_hx711_io_target.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hx711_io_pkg.sv
// Shared definitions for the HX711 IO-bus target: register offsets, gain
// codes with their PD_SCK pulse counts, engine states and STATUS bit positions.
package hx711_io_pkg;

  localparam logic [3:0] OFF_CTRL    = 4'h0;
  localparam logic [3:0] OFF_STATUS  = 4'h2;
  localparam logic [3:0] OFF_DATA_LO = 4'h4;
  localparam logic [3:0] OFF_DATA_HI = 4'h6;
  localparam logic [3:0] OFF_COUNT   = 4'h8;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_IRQ_EN = 1;

  localparam int STAT_VALID   = 0;
  localparam int STAT_BUSY    = 1;
  localparam int STAT_OVERRUN = 2;

  localparam logic [1:0] GAIN_A128 = 2'b00;
  localparam logic [1:0] GAIN_B32  = 2'b01;
  localparam logic [1:0] GAIN_A64  = 2'b10;

  localparam logic [4:0] PULSES_A128 = 5'd25;
  localparam logic [4:0] PULSES_B32  = 5'd26;
  localparam logic [4:0] PULSES_A64  = 5'd27;

  localparam logic [4:0] DATA_BITS = 5'd24;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_RDY,
    ST_HIGH,
    ST_LOW,
    ST_DONE
  } hx_state_t;

  // Gain code 11 is reserved on the HX711; it is treated as chA x128.
  function automatic logic [4:0] pulses_for_gain(input logic [1:0] gain);
    case (gain)
      GAIN_B32: return PULSES_B32;
      GAIN_A64: return PULSES_A64;
      default:  return PULSES_A128;
    endcase
  endfunction

endpackage

// File: rtl/hx711_shifter.sv
// HX711 serial engine: synchronizes DOUT, generates PD_SCK with a down-counting
// phase timer, shifts in a 24-bit sample MSB first and pulses done for one cycle.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | engine off, SCK low
// WAIT_RDY  | waiting for DOUT low (sample ready); gain pulse count latched on exit
// HIGH      | SCK high for SCK_HALF cycles; data bit sampled on the last cycle
// LOW       | SCK low for SCK_HALF cycles; bit counter advances at the end
// DONE      | one-cycle sample-complete pulse
module hx711_shifter
  import hx711_io_pkg::*;
#(
  parameter int SCK_HALF = 50
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [1:0]  gain,
  input  logic        dt,
  output logic        sck,
  output logic        busy,
  output logic        done,
  output logic [23:0] sample
);

  localparam int TW = $clog2(SCK_HALF);
  localparam logic [TW-1:0] TIMER_LOAD = TW'(SCK_HALF - 1);

  hx_state_t     state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [4:0]    n_q, n_d;
  logic [4:0]    total_q, total_d;
  logic [23:0]   shift_q, shift_d;
  logic          dt_meta_q, dt_sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      n_q       <= '0;
      total_q   <= '0;
      shift_q   <= '0;
      dt_meta_q <= 1'b0;
      dt_sync_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      n_q       <= n_d;
      total_q   <= total_d;
      shift_q   <= shift_d;
      dt_meta_q <= dt;
      dt_sync_q <= dt_meta_q;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    n_d     = n_q;
    total_d = total_q;
    shift_d = shift_q;
    case (state_q)
      ST_IDLE: begin
        if (en) state_d = ST_WAIT_RDY;
      end
      ST_WAIT_RDY: begin
        if (!dt_sync_q) begin
          state_d = ST_HIGH;
          n_d     = '0;
          total_d = pulses_for_gain(gain);
          timer_d = TIMER_LOAD;
        end
      end
      ST_HIGH: begin
        if (timer_q == '0) begin
          if (n_q < DATA_BITS) shift_d = {shift_q[22:0], dt_sync_q};
          state_d = ST_LOW;
          timer_d = TIMER_LOAD;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      ST_LOW: begin
        if (timer_q == '0) begin
          n_d     = n_q + 5'd1;
          timer_d = TIMER_LOAD;
          // EN is deliberately not consulted here: the gain pulses must finish.
          state_d = (n_q + 5'd1 == total_q) ? ST_DONE : ST_HIGH;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      ST_DONE: begin
        state_d = en ? ST_WAIT_RDY : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign sck    = (state_q == ST_HIGH);
  assign busy   = (state_q == ST_HIGH) || (state_q == ST_LOW) || (state_q == ST_DONE);
  assign done   = (state_q == ST_DONE);
  assign sample = shift_q;

endmodule

// File: rtl/hx711_io_target.sv
// IO-bus responder for the HX711 load-cell engine: address decode, one-cycle
// acknowledge, control/status/data registers, sample shadow and level irq.
module hx711_io_target
  import hx711_io_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter int          SCK_HALF  = 50
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] io_address,
  input  logic        io_bus_enable,
  input  logic [1:0]  io_byte_enable,
  input  logic        io_rw,
  input  logic [15:0] io_write_data,
  output logic [15:0] io_read_data,
  output logic        io_acknowledge,
  output logic        io_irq,
  input  logic        hx711_dt,
  output logic        hx711_sck
);

  logic        ack_q, served_q;
  logic [15:0] rdata_q, rdata_d;
  logic [3:0]  ctrl_q;
  logic        valid_q, overrun_q;
  logic [15:0] count_q;
  logic [23:0] data_q;
  logic [7:0]  shadow_q;

  logic        sh_busy, sh_done;
  logic [23:0] sh_sample;

  logic        hit, rd, wr, rd_lo, rd_hi, ctrl_wr, ovr_clr;
  logic [3:0]  offset;
  logic        unused_bits;

  hx711_shifter #(.SCK_HALF(SCK_HALF)) u_shifter (
    .clk    (clk),
    .reset  (reset),
    .en     (ctrl_q[CTRL_EN]),
    .gain   (ctrl_q[3:2]),
    .dt     (hx711_dt),
    .sck    (hx711_sck),
    .busy   (sh_busy),
    .done   (sh_done),
    .sample (sh_sample)
  );

  // served_q stops a bridge that holds bus_enable past the ack from being served twice.
  assign hit     = io_bus_enable && (io_address[15:4] == BASE_ADDR[15:4]) && !ack_q && !served_q;
  assign offset  = io_address[3:0];
  assign rd      = hit && io_rw;
  assign wr      = hit && !io_rw;
  assign rd_lo   = rd && (offset == OFF_DATA_LO);
  assign rd_hi   = rd && (offset == OFF_DATA_HI);
  assign ctrl_wr = wr && (offset == OFF_CTRL) && io_byte_enable[0];
  assign ovr_clr = wr && (offset == OFF_STATUS) && io_byte_enable[0] && io_write_data[STAT_OVERRUN];

  assign unused_bits = ^{io_byte_enable[1], io_write_data[15:4]};

  always_comb begin
    rdata_d = '0;
    case (offset)
      OFF_CTRL:    rdata_d = {12'd0, ctrl_q};
      OFF_STATUS:  rdata_d = {13'd0, overrun_q, sh_busy, valid_q};
      OFF_DATA_LO: rdata_d = data_q[15:0];
      OFF_DATA_HI: rdata_d = {{8{shadow_q[7]}}, shadow_q};
      OFF_COUNT:   rdata_d = count_q;
      default:     rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ack_q     <= 1'b0;
      served_q  <= 1'b0;
      rdata_q   <= '0;
      ctrl_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      count_q   <= '0;
      data_q    <= '0;
      shadow_q  <= '0;
    end else begin
      ack_q    <= hit;
      served_q <= io_bus_enable && (served_q || hit);
      rdata_q  <= rd ? rdata_d : '0;
      if (ctrl_wr) ctrl_q <= io_write_data[3:0];
      if (rd_lo) shadow_q <= data_q[23:16];
      if (sh_done) begin
        // A fresh sample beats a simultaneous DATA_HI read and an OVERRUN clear.
        data_q  <= sh_sample;
        count_q <= count_q + 16'd1;
        valid_q <= 1'b1;
        if (valid_q && !rd_hi) overrun_q <= 1'b1;
        else if (ovr_clr)      overrun_q <= 1'b0;
      end else begin
        if (rd_hi)   valid_q   <= 1'b0;
        if (ovr_clr) overrun_q <= 1'b0;
      end
    end
  end

  assign io_acknowledge = ack_q;
  assign io_read_data   = rdata_q;
  assign io_irq         = ctrl_q[CTRL_IRQ_EN] && valid_q;

endmodule

// File: tb/tb_hx711_io_target.sv
// Directed bench for hx711_io_target: an HX711 pin model, a register-level
// model of the block, and a per-cycle compare of ack, read data and irq.
module tb_hx711_io_target;

  localparam int SCK_HALF = 50;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] io_address = '0;
  logic        io_bus_enable = 1'b0;
  logic [1:0]  io_byte_enable = '0;
  logic        io_rw = 1'b0;
  logic [15:0] io_write_data = '0;
  logic [15:0] io_read_data;
  logic        io_acknowledge;
  logic        io_irq;
  logic        hx711_dt = 1'b1;
  logic        hx711_sck;

  always #10 clk = ~clk;

  hx711_io_target #(.BASE_ADDR(16'h0000), .SCK_HALF(SCK_HALF)) dut (
    .clk            (clk),
    .reset          (reset),
    .io_address     (io_address),
    .io_bus_enable  (io_bus_enable),
    .io_byte_enable (io_byte_enable),
    .io_rw          (io_rw),
    .io_write_data  (io_write_data),
    .io_read_data   (io_read_data),
    .io_acknowledge (io_acknowledge),
    .io_irq         (io_irq),
    .hx711_dt       (hx711_dt),
    .hx711_sck      (hx711_sck)
  );

  int checks = 0;
  int errors = 0;

  // register-level model
  logic [3:0]  m_ctrl = '0;
  logic        m_valid = 1'b0, m_overrun = 1'b0;
  logic [15:0] m_count = '0;
  logic [23:0] m_sample = '0;
  logic [7:0]  m_shadow = '0;

  logic        bus_active = 1'b0, settling = 1'b0;
  logic        exp_pending = 1'b0, exp_is_read = 1'b0;
  logic [15:0] exp_rd = '0;
  int          acks_seen = 0;

  logic [23:0] conv_sample = '0;
  int          pcount = 0;
  logic        phase_chk_en = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int pulses(input logic [1:0] g);
    return (g == 2'b01) ? 26 : (g == 2'b10) ? 27 : 25;
  endfunction

  function automatic logic [15:0] model_read(input logic [3:0] off);
    case (off)
      4'h0: return {12'd0, m_ctrl};
      4'h2: return {13'd0, m_overrun, 1'b0, m_valid};
      4'h4: return m_sample[15:0];
      4'h6: return {{8{m_shadow[7]}}, m_shadow};
      4'h8: return m_count;
      default: return 16'h0000;
    endcase
  endfunction

  // HX711 pin model: each rising SCK shifts out the next bit, MSB first; DOUT goes high after bit 0.
  always @(posedge hx711_sck) begin
    pcount++;
    hx711_dt = (pcount <= 24) ? conv_sample[24 - pcount] : 1'b1;
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (io_acknowledge) begin
        acks_seen++;
        checks++;
        if (!exp_pending) begin
          errors++;
          $display("FAIL unexpected_ack: addr %0h got ack 1 expected 0", io_address);
        end else begin
          exp_pending = 1'b0;
          if (exp_is_read && io_read_data !== exp_rd) begin
            errors++;
            $display("FAIL read_data @%0h: got %0h expected %0h", io_address, io_read_data, exp_rd);
          end
        end
      end else begin
        check("read_data_idle", io_read_data, 16'h0000);
      end
      if (!bus_active && !settling) check("irq", io_irq, m_ctrl[1] & m_valid);
    end
  end

  int   run_len = 0;
  logic sck_prev = 1'b0;
  always @(negedge clk) begin
    if (reset || !phase_chk_en) begin
      run_len  = 0;
      sck_prev = hx711_sck;
    end else if (hx711_sck != sck_prev) begin
      if (sck_prev) check("sck_high_len", run_len, SCK_HALF);
      else if (pcount >= 2) check("sck_low_len", run_len, SCK_HALF);
      run_len  = 1;
      sck_prev = hx711_sck;
    end else begin
      run_len++;
    end
  end

  task automatic bus_xfer(input logic [15:0] addr, input logic rw, input logic [15:0] wdata,
                          input logic [1:0] be, input logic expect_ack, input logic [15:0] exp,
                          input int hold);
    int start;
    logic got;
    @(negedge clk); #1;
    bus_active  = 1'b1;
    exp_pending = expect_ack;
    exp_is_read = rw;
    exp_rd      = exp;
    start       = acks_seen;
    io_address = addr; io_rw = rw; io_write_data = wdata; io_byte_enable = be;
    io_bus_enable = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk); #1;
      if (acks_seen != start) got = 1'b1;
    end
    if (expect_ack) check("ack_seen", got, 1'b1);
    else            check("no_ack_on_miss", got, 1'b0);
    repeat (hold) @(negedge clk);
    #1;
    io_bus_enable = 1'b0;
    if (expect_ack) check("single_ack", acks_seen - start, 1);
    exp_pending = 1'b0;
    if (got && rw) begin
      if (addr[3:0] == 4'h4) m_shadow = m_sample[23:16];
      if (addr[3:0] == 4'h6) m_valid = 1'b0;
    end
    if (got && !rw && be[0]) begin
      if (addr[3:0] == 4'h0) m_ctrl = wdata[3:0];
      if (addr[3:0] == 4'h2 && wdata[2]) m_overrun = 1'b0;
    end
    @(negedge clk); #1;
    bus_active = 1'b0;
  endtask

  task automatic rd(input logic [15:0] addr, input logic [15:0] exp);
    bus_xfer(addr, 1'b1, 16'h0000, 2'b00, 1'b1, exp, 0);
  endtask

  task automatic wr(input logic [15:0] addr, input logic [15:0] data, input logic [1:0] be);
    bus_xfer(addr, 1'b0, data, be, 1'b1, 16'h0000, 0);
  endtask

  task automatic present_and_wait(input logic [23:0] s, input int exp_pulses);
    int total;
    total = pulses(m_ctrl[3:2]);
    check("pulse_model", total, exp_pulses);
    settling    = 1'b1;
    conv_sample = s;
    pcount      = 0;
    @(negedge clk);
    hx711_dt = 1'b0;
    for (int i = 0; i < 8000 && !(pcount == total && hx711_sck == 1'b0); i++) @(negedge clk);
    repeat (SCK_HALF + 4) @(negedge clk);
    check("pulse_count", pcount, exp_pulses);
    if (m_valid) m_overrun = 1'b1;
    m_valid  = 1'b1;
    m_sample = s;
    m_count  = m_count + 16'd1;
    @(negedge clk);
    settling = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_sck", hx711_sck, 1'b0);
    check("reset_irq", io_irq, 1'b0);
    check("reset_ack", io_acknowledge, 1'b0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    rd(16'h0000, 16'h0000);
    rd(16'h0002, 16'h0000);
    rd(16'h0008, 16'h0000);

    wr(16'h0000, 16'h0003, 2'b11);
    present_and_wait(24'h800001, 25);
    check("irq_set", io_irq, 1'b1);
    rd(16'h0004, 16'h0001);
    check("irq_held_after_lo", io_irq, 1'b1);
    rd(16'h0006, 16'hFF80);
    check("irq_clear", io_irq, 1'b0);
    rd(16'h0008, 16'h0001);
    rd(16'h0002, 16'h0000);

    wr(16'h0000, 16'h000B, 2'b01);
    present_and_wait(24'h123456, 27);
    rd(16'h0004, 16'h3456);
    rd(16'h0006, 16'h0012);
    rd(16'h0008, 16'h0002);

    present_and_wait(24'h00ABCD, 27);
    present_and_wait(24'h7FFFFE, 27);
    rd(16'h0002, 16'h0005);
    rd(16'h0004, 16'hFFFE);
    rd(16'h0006, 16'h007F);
    rd(16'h0002, 16'h0004);
    wr(16'h0002, 16'h0004, 2'b01);
    rd(16'h0002, 16'h0000);
    rd(16'h0008, 16'h0004);

    bus_xfer(16'h0000, 1'b1, 16'h0000, 2'b00, 1'b1, 16'h000B, 3);
    bus_xfer(16'h0010, 1'b1, 16'h0000, 2'b00, 1'b0, 16'h0000, 0);
    rd(16'h000A, 16'h0000);
    wr(16'h000A, 16'hFFFF, 2'b11);
    wr(16'h0000, 16'h0000, 2'b10);
    rd(16'h0000, 16'h000B);
    for (int off = 0; off < 16; off += 2) rd(16'(off), model_read(4'(off)));

    // reset during bit 12 of a conversion
    wr(16'h0000, 16'h0001, 2'b01);
    settling     = 1'b1;
    phase_chk_en = 1'b0;
    conv_sample  = 24'h0F0F0F;
    pcount       = 0;
    @(negedge clk);
    hx711_dt = 1'b0;
    for (int i = 0; i < 8000 && !(pcount == 12 && hx711_sck == 1'b1); i++) @(negedge clk);
    check("reached_bit12", pcount, 12);
    repeat (10) @(negedge clk);
    #3 reset = 1'b1;
    #1;
    check("sck_drops_on_reset", hx711_sck, 1'b0);
    check("irq_on_reset", io_irq, 1'b0);
    m_ctrl = '0; m_valid = 1'b0; m_overrun = 1'b0; m_count = '0; m_sample = '0; m_shadow = '0;
    pcount = 0;
    hx711_dt = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (300) @(negedge clk);
    check("no_pulses_after_reset", pcount, 0);
    settling = 1'b0;
    rd(16'h0002, 16'h0000);
    rd(16'h0000, 16'h0000);
    rd(16'h0008, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
